// File: rtl/sync_load_arb.sv
// Round-robin arbiter/sequencer in front of a bank of load-enabled sync registers:
// one grant at a time, a single enabled-clock ld strobe per transfer, then an ack pulse.

module sync_load_arb_lane #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic             req,
    input  logic             ack,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    data,
    output logic             elig,
    output logic [AW+DW-1:0] xfer
);
    // Masked while its ack is out, so a requester still dropping req is not re-granted.
    assign elig = req & ~ack;
    assign xfer = {addr, data};
endmodule

module sync_load_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int HOLD = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 clk,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        d,
    output logic [(1<<AW)-1:0]   ld,
    output logic                 busy,
    output logic [2:0]           gnt_id
);
    localparam int IW = 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    state_t                state, state_nxt;
    xfer_t [NREQ-1:0]      lane_x;
    xfer_t                 sel_x, lat;
    logic [NREQ-1:0]       elig;
    logic [7:0]            elig_w;
    logic [IW-1:0]         ptr, pick, cand_idx;
    logic                  pick_vld;
    logic [3:0]            hold_cnt;
    logic [DW-1:0]         d_last;
    logic                  grant_edge, load_edge;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            sync_load_arb_lane #(.AW(AW), .DW(DW)) u_lane (
                .req  (req[gi]),
                .ack  (ack[gi]),
                .addr (req_addr[gi*AW +: AW]),
                .data (req_data[gi*DW +: DW]),
                .elig (elig[gi]),
                .xfer (lane_x[gi])
            );
        end
    endgenerate

    // Search starts just past the last grantee, so it drops to lowest priority.
    always_comb begin
        elig_w           = '0;
        elig_w[NREQ-1:0] = elig;
        pick             = '0;
        pick_vld         = 1'b0;
        cand_idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(ptr) + k) % NREQ);
            if (!pick_vld && elig_w[cand_idx]) begin
                pick_vld = 1'b1;
                pick     = cand_idx;
            end
        end
    end

    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick == IW'(i)) sel_x = lane_x[i];
    end

    assign grant_edge = clk && (state == S_IDLE) && pick_vld;
    assign load_edge  = clk && (state == S_LOAD);

    always_ff @(posedge sys_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clk) begin
            case (state)
                S_IDLE:  if (pick_vld) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = (HOLD == 0) ? S_IDLE : S_HOLD;
                S_HOLD:  if (hold_cnt <= 4'd1) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ld is gated by reset so an aborted LOAD never reaches the bank.
    always_comb begin
        ld   = '0;
        d    = d_last;
        busy = (state != S_IDLE);
        if (state == S_LOAD) begin
            d = lat.data;
            if (clk && !reset) ld[lat.addr] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            lat      <= '0;
            ptr      <= IW'(NREQ - 1);
            gnt_id   <= '0;
            hold_cnt <= '0;
            ack      <= '0;
            d_last   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                ack[i] <= load_edge && (gnt_id == IW'(i));
            if (grant_edge) begin
                lat    <= sel_x;
                ptr    <= pick;
                gnt_id <= pick;
            end
            if (load_edge) begin
                d_last   <= lat.data;
                hold_cnt <= 4'(HOLD);
            end else if (clk && state == S_HOLD && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    a_ld_onehot:  assert property (@(posedge sys_clk) disable iff (reset) $onehot0(ld));
    a_ack_onehot: assert property (@(posedge sys_clk) disable iff (reset) $onehot0(ack));
    a_ld_in_load: assert property (@(posedge sys_clk) (ld != '0) |-> (state == S_LOAD));
endmodule

// File: tb/tb_sync_load_arb.sv
// Bench for sync_load_arb: directed scenarios plus randomized traffic against a
// transfer-level model (countdown of enabled clocks per transfer, RR search, bank array).

module tb_sync_load_arb;
    localparam int NREQ = 4, DW = 16, AW = 3, HOLD = 1, NR = 8;

    logic                sys_clk = 1'b0;
    logic                reset = 1'b1, clk_en = 1'b1, bank_clr = 1'b1;
    logic [NREQ-1:0]     req = '0, req0v = '0, drop0 = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     ack, ack0;
    logic [DW-1:0]       d, d0;
    logic [NR-1:0]       ld, ld0;
    logic                busy, busy0;
    logic [2:0]          gnt_id, gnt0;

    int n_vec = 0, n_err = 0;

    int              m_left = 0, m_ptr = NREQ - 1, m_gnt = 0, m_addr = 0;
    logic [DW-1:0]   m_data = '0, m_dlast = '0;
    logic [NREQ-1:0] m_ack = '0;
    logic [DW-1:0]   m_bank [NR];
    logic [DW-1:0]   o_bank [NR];

    sync_load_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .HOLD(HOLD)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .clk(clk_en), .req(req),
        .req_addr(req_addr), .req_data(req_data), .ack(ack), .d(d),
        .ld(ld), .busy(busy), .gnt_id(gnt_id)
    );

    sync_load_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .HOLD(0)) u_dut0 (
        .sys_clk(sys_clk), .reset(reset), .clk(clk_en), .req(req0v),
        .req_addr(req_addr), .req_data(req_data), .ack(ack0), .d(d0),
        .ld(ld0), .busy(busy0), .gnt_id(gnt0)
    );

    always #5 sys_clk = ~sys_clk;

    // What the register bank actually receives from the DUT.
    always @(posedge sys_clk)
        for (int r = 0; r < NR; r++)
            if (bank_clr) o_bank[r] <= '0;
            else if (ld[r]) o_bank[r] <= d;

    task automatic model_edge();
        logic [NREQ-1:0] nack, elig;
        nack = '0;
        if (reset) begin
            m_left = 0; m_ptr = NREQ - 1; m_gnt = 0; m_addr = 0;
            m_data = '0; m_dlast = '0; m_ack = '0;
            return;
        end
        if (clk_en) begin
            if (m_left == HOLD + 1) begin
                m_bank[m_addr] = m_data;
                m_dlast        = m_data;
                nack[m_gnt]    = 1'b1;
            end
            if (m_left > 0) m_left--;
            else begin
                elig = req & ~m_ack;
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (m_left == 0 && elig[i]) begin
                        m_gnt = i; m_ptr = i; m_left = HOLD + 1;
                        m_addr = int'(req_addr[i*AW +: AW]);
                        m_data = req_data[i*DW +: DW];
                    end
                end
            end
        end
        m_ack = nack;
    endtask

    function automatic logic [NR-1:0] e_ld();
        e_ld = '0;
        if (m_left == HOLD + 1 && clk_en && !reset) e_ld[m_addr] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] e_d();
        e_d = (m_left == HOLD + 1) ? m_data : m_dlast;
    endfunction

    // One sys_clk cycle; requesters drop req once they see their ack.
    task automatic cyc();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        req   = req & ~ack;
        req0v = req0v & ~drop0;
        drop0 = ack0;
    endtask

    task automatic do_reset();
        reset = 1'b1; bank_clr = 1'b1; clk_en = 1'b1;
        req = '0; req0v = '0; drop0 = '0;
        for (int r = 0; r < NR; r++) m_bank[r] = '0;
        cyc(); cyc();
        reset = 1'b0; bank_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bank_clr = 1'b1; req = 4'b1111;
        cyc(); cyc();
        #1;
        n_vec++; if (ack !== 4'b0)    begin n_err++; $display("FAIL rst_ack: got %h want 0", ack); end
        n_vec++; if (ld !== 8'h00)    begin n_err++; $display("FAIL rst_ld: got %h want 00", ld); end
        n_vec++; if (d !== 16'h0)     begin n_err++; $display("FAIL rst_d: got %h want 0000", d); end
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL rst_gnt: got %0d want 0", gnt_id); end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_addr[0 +: AW] = 3'd5; req_data[0 +: DW] = 16'hBEEF; req = 4'b0001;
        cyc(); #1;
        n_vec++; if (ld !== 8'h20)      begin n_err++; $display("FAIL single_ld: got %h want 20", ld); end
        n_vec++; if (d !== 16'hBEEF)    begin n_err++; $display("FAIL single_d: got %h want beef", d); end
        n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL single_busy1: got %b want 1", busy); end
        n_vec++; if (ack !== 4'b0000)   begin n_err++; $display("FAIL single_ack_early: got %b want 0000", ack); end
        cyc(); #1;
        n_vec++; if (ack !== 4'b0001)   begin n_err++; $display("FAIL single_ack: got %b want 0001", ack); end
        n_vec++; if (ld !== 8'h00)      begin n_err++; $display("FAIL single_ld_off: got %h want 00", ld); end
        n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL single_busy2: got %b want 1", busy); end
        cyc(); #1;
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL single_idle: got %b want 0", busy); end
        n_vec++; if (ack !== 4'b0000)   begin n_err++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        n_vec++; if (d !== 16'hBEEF)    begin n_err++; $display("FAIL single_d_hold: got %h want beef", d); end
        n_vec++; if (o_bank[5] !== 16'hBEEF) begin n_err++; $display("FAIL single_bank: got %h want beef", o_bank[5]); end
    endtask

    task automatic test_rr();
        int n_acks;
        logic [NREQ-1:0] prev;
        n_acks = 0; prev = '0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 1);
            req_data[i*DW +: DW] = DW'($urandom);
        end
        req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            cyc(); #1;
            if (ack !== 4'b0000) begin
                n_vec++;
                if (n_acks >= NREQ || ack !== 4'(1 << n_acks)) begin
                    n_err++; $display("FAIL rr_order: got %b want %b", ack, 4'(1 << n_acks));
                end
                n_vec++;
                if ((ack & prev) !== 4'b0) begin n_err++; $display("FAIL rr_ack_width: got %b after %b", ack, prev); end
                n_acks++;
            end
            prev = ack;
        end
        n_vec++; if (n_acks != NREQ) begin n_err++; $display("FAIL rr_count: got %0d want %0d", n_acks, NREQ); end
    endtask

    task automatic test_clk_en();
        int loads;
        loads = 0;
        do_reset();
        req_addr[0 +: AW] = AW'($urandom); req_data[0 +: DW] = DW'($urandom); req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            clk_en = (c % 2 == 0);
            #1;
            if (ld !== 8'h00) loads++;
            n_vec++; if (ld !== e_ld())     begin n_err++; $display("FAIL ce_ld c%0d: got %h want %h", c, ld, e_ld()); end
            n_vec++; if (d !== e_d())       begin n_err++; $display("FAIL ce_d c%0d: got %h want %h", c, d, e_d()); end
            n_vec++; if (ack !== m_ack)     begin n_err++; $display("FAIL ce_ack c%0d: got %b want %b", c, ack, m_ack); end
            n_vec++; if (busy !== (m_left > 0)) begin n_err++; $display("FAIL ce_busy c%0d: got %b want %b", c, busy, m_left > 0); end
            cyc();
        end
        clk_en = 1'b1;
        n_vec++; if (loads != 1) begin n_err++; $display("FAIL ce_loads: got %0d want 1", loads); end
    endtask

    task automatic test_hold0();
        int a0, a1, first, ld_cnt;
        a0 = 0; a1 = 0; first = -1; ld_cnt = 0;
        do_reset();
        req0v = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            cyc(); #1;
            if (ack0[0]) begin a0++; if (first < 0) first = 0; end
            if (ack0[1]) begin a1++; if (first < 0) first = 1; end
        end
        n_vec++; if (first != 0) begin n_err++; $display("FAIL h0_first: got %0d want 0", first); end
        n_vec++; if (a0 != 1)    begin n_err++; $display("FAIL h0_ack0: got %0d want 1", a0); end
        n_vec++; if (a1 != 1)    begin n_err++; $display("FAIL h0_ack1: got %0d want 1", a1); end
        a0 = 0;
        do_reset();
        req0v = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            if (ack0[0]) a0++;
            if (ld0 !== 8'h00) ld_cnt++;
        end
        n_vec++; if (a0 != 1)     begin n_err++; $display("FAIL h0_double_ack: got %0d want 1", a0); end
        n_vec++; if (ld_cnt != 1) begin n_err++; $display("FAIL h0_double_ld: got %0d want 1", ld_cnt); end
    endtask

    task automatic test_reset_load();
        do_reset();
        req_addr[1*AW +: AW] = 3'd2; req_data[1*DW +: DW] = 16'h1234; req = 4'b0010;
        cyc();
        reset = 1'b1; #1;
        n_vec++; if (ld !== 8'h00) begin n_err++; $display("FAIL rl_ld: got %h want 00", ld); end
        cyc();
        reset = 1'b0;
        req_addr[0 +: AW] = 3'd4; req_data[0 +: DW] = 16'h5678; req = 4'b0011;
        #1;
        n_vec++; if (ack !== 4'b0)  begin n_err++; $display("FAIL rl_ack: got %b want 0000", ack); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rl_busy: got %b want 0", busy); end
        n_vec++; if (o_bank[2] !== 16'h0) begin n_err++; $display("FAIL rl_bank: got %h want 0000", o_bank[2]); end
        cyc(); #1;
        n_vec++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL rl_first: got %0d want 0", gnt_id); end
        n_vec++; if (ld !== 8'h10)    begin n_err++; $display("FAIL rl_ld0: got %h want 10", ld); end
        cyc(); #1;
        n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL rl_ack0: got %b want 0001", ack); end
        n_vec++; if (o_bank[4] !== 16'h5678) begin n_err++; $display("FAIL rl_bank4: got %h want 5678", o_bank[4]); end
    endtask

    task automatic test_data_change();
        do_reset();
        req_addr[0 +: AW] = 3'd3; req_data[0 +: DW] = 16'hAAAA; req = 4'b0001;
        cyc();
        req_addr[0 +: AW] = 3'd6; req_data[0 +: DW] = 16'h5555; #1;
        n_vec++; if (d !== 16'hAAAA) begin n_err++; $display("FAIL dc_d: got %h want aaaa", d); end
        n_vec++; if (ld !== 8'h08)   begin n_err++; $display("FAIL dc_ld: got %h want 08", ld); end
        cyc(); #1;
        n_vec++; if (o_bank[3] !== 16'hAAAA) begin n_err++; $display("FAIL dc_bank3: got %h want aaaa", o_bank[3]); end
        n_vec++; if (o_bank[6] !== 16'h0)    begin n_err++; $display("FAIL dc_bank6: got %h want 0000", o_bank[6]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clk_en = ($urandom_range(3) != 0);
            reset  = ($urandom_range(99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if ($urandom_range(9) == 0) begin
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            #1;
            n_vec++; if (ld !== e_ld())     begin n_err++; $display("FAIL rnd_ld c%0d: got %h want %h", c, ld, e_ld()); end
            n_vec++; if (d !== e_d())       begin n_err++; $display("FAIL rnd_d c%0d: got %h want %h", c, d, e_d()); end
            n_vec++; if (ack !== m_ack)     begin n_err++; $display("FAIL rnd_ack c%0d: got %b want %b", c, ack, m_ack); end
            n_vec++; if (busy !== (m_left > 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_left > 0); end
            n_vec++; if (gnt_id !== 3'(m_gnt))  begin n_err++; $display("FAIL rnd_gnt c%0d: got %0d want %0d", c, gnt_id, m_gnt); end
            cyc();
        end
        reset = 1'b0; clk_en = 1'b1;
        for (int r = 0; r < NR; r++) begin
            n_vec++;
            if (o_bank[r] !== m_bank[r]) begin n_err++; $display("FAIL rnd_bank%0d: got %h want %h", r, o_bank[r], m_bank[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_clk_en();
        test_hold0();
        test_reset_load();
        test_data_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
